// File: rtl/prog_frame_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : prog_frame_loader_if
// Brief    : Byte-receiver input, ICCM write port and status bundle of the
//            programming frame loader.
// Revision : 1.0 - initial release
// ============================================================================
interface prog_frame_loader_if #(
  parameter int ADDR_W = 12
) ();
  logic              prog_i;
  logic              rx_dv_i;
  logic [7:0]        rx_byte_i;
  logic              we_o;
  logic [ADDR_W-1:0] addr_o;
  logic [31:0]       wdata_o;
  logic              busy_o;
  logic              done_o;
  logic [1:0]        err_o;
  logic              prog_rst_no;

  // Loader side: consumes the byte stream, drives the ICCM port and status
  modport slave (
    input  prog_i, rx_dv_i, rx_byte_i,
    output we_o, addr_o, wdata_o, busy_o, done_o, err_o, prog_rst_no
  );

  // Host side: supplies bytes and mode, observes writes and status
  modport master (
    output prog_i, rx_dv_i, rx_byte_i,
    input  we_o, addr_o, wdata_o, busy_o, done_o, err_o, prog_rst_no
  );
endinterface
`default_nettype wire

// File: rtl/prog_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_frame_loader
// Brief    : Framed, checksum-verified boot-image loader. Parses
//            sync / len_lo / len_hi / payload / checksum, writes one ICCM
//            word per 4 payload bytes and holds the core in reset until a
//            frame verifies.
// Revision : 1.0 - initial release
// ============================================================================
module prog_frame_loader #(
  parameter int          ADDR_W      = 12,
  parameter int          MAX_WORDS   = 1024,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter logic [23:0] TIMEOUT_CYC = 24'd1_000_000
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  prog_frame_loader_if.slave bus
);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_sync   = 3'd1;
  localparam logic [2:0] c_st_len_lo = 3'd2;
  localparam logic [2:0] c_st_len_hi = 3'd3;
  localparam logic [2:0] c_st_data   = 3'd4;
  localparam logic [2:0] c_st_csum   = 3'd5;
  localparam logic [2:0] c_st_done   = 3'd6;
  localparam logic [2:0] c_st_err    = 3'd7;

  localparam logic [15:0] c_max_words = 16'(MAX_WORDS);
  localparam logic [1:0]  c_err_len   = 2'd1;
  localparam logic [1:0]  c_err_csum  = 2'd2;
  localparam logic [1:0]  c_err_abort = 2'd3;

  logic [2:0]        r_state;
  logic [15:0]       r_len;
  logic [15:0]       r_widx;      // index of the word currently being assembled
  logic [1:0]        r_k;         // byte position within the current word
  logic [23:0]       r_asm;       // lower three bytes of the word in flight
  logic [7:0]        r_sum;
  logic [23:0]       r_tmo;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_done;
  logic [1:0]        r_err;
  logic              r_prog_rst_n;
  logic              r_last_ok;   // last attempted load succeeded (or none since reset)

  logic [7:0]        w_byte;
  logic [15:0]       w_len;
  logic [7:0]        w_sum_next;

  assign w_byte     = bus.rx_byte_i;
  assign w_len      = {w_byte, r_len[7:0]};
  assign w_sum_next = r_sum + w_byte;

  // Frame parser, write generation, timeout and sticky status
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state      <= c_st_idle;
      r_len        <= '0;
      r_widx       <= '0;
      r_k          <= '0;
      r_asm        <= '0;
      r_sum        <= '0;
      r_tmo        <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_done       <= 1'b0;
      r_err        <= '0;
      r_prog_rst_n <= 1'b1;
      r_last_ok    <= 1'b1;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (bus.prog_i) begin
            r_state      <= c_st_sync;
            r_prog_rst_n <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= '0;
            r_widx       <= '0;
            r_k          <= '0;
            r_sum        <= '0;
          end
        end
        c_st_sync: begin
          if (!bus.prog_i) begin
            r_state      <= c_st_idle;
            r_prog_rst_n <= r_last_ok;
          end else if (bus.rx_dv_i && (w_byte == SYNC_BYTE)) begin
            r_state <= c_st_len_lo;
            r_tmo   <= '0;
          end
        end
        c_st_len_lo, c_st_len_hi, c_st_data, c_st_csum: begin
          if (!bus.prog_i) begin
            // Abort takes priority; any coincident byte is dropped
            r_state   <= c_st_err;
            r_err     <= c_err_abort;
            r_last_ok <= 1'b0;
          end else if (bus.rx_dv_i) begin
            r_tmo <= '0;
            r_sum <= w_sum_next;
            case (r_state)
              c_st_len_lo: begin
                r_len[7:0] <= w_byte;
                r_state    <= c_st_len_hi;
              end
              c_st_len_hi: begin
                r_len <= w_len;
                if ((w_len == 16'd0) || (w_len > c_max_words)) begin
                  r_state   <= c_st_err;
                  r_err     <= c_err_len;
                  r_last_ok <= 1'b0;
                end else begin
                  r_state <= c_st_data;
                end
              end
              c_st_data: begin
                r_k <= r_k + 2'd1;
                if (r_k == 2'd3) begin
                  r_we    <= 1'b1;
                  r_addr  <= r_widx[ADDR_W-1:0];
                  r_wdata <= {w_byte, r_asm};
                  r_widx  <= r_widx + 16'd1;
                  if (r_widx == (r_len - 16'd1)) begin
                    r_state <= c_st_csum;
                  end
                end else begin
                  r_asm[8*r_k +: 8] <= w_byte;
                end
              end
              default: begin
                // Checksum byte: the full running sum must wrap to zero
                if (w_sum_next == 8'd0) begin
                  r_state      <= c_st_done;
                  r_done       <= 1'b1;
                  r_prog_rst_n <= 1'b1;
                  r_last_ok    <= 1'b1;
                end else begin
                  r_state   <= c_st_err;
                  r_err     <= c_err_csum;
                  r_last_ok <= 1'b0;
                end
              end
            endcase
          end else if (r_tmo == (TIMEOUT_CYC - 24'd1)) begin
            r_state   <= c_st_err;
            r_err     <= c_err_abort;
            r_last_ok <= 1'b0;
          end else begin
            r_tmo <= r_tmo + 24'd1;
          end
        end
        default: begin
          // DONE / ERR: hold status until programming mode is released
          if (!bus.prog_i) begin
            r_state <= c_st_idle;
          end
        end
      endcase
    end
  end

  assign bus.we_o        = r_we;
  assign bus.addr_o      = r_addr;
  assign bus.wdata_o     = r_wdata;
  assign bus.busy_o      = (r_state >= c_st_sync) && (r_state <= c_st_csum);
  assign bus.done_o      = r_done;
  assign bus.err_o       = r_err;
  assign bus.prog_rst_no = r_prog_rst_n;

endmodule
`default_nettype wire

// File: tb/tb_prog_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_frame_loader
// Brief    : Directed self-checking bench for prog_frame_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_frame_loader;

  localparam int ADDR_W = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];

  prog_frame_loader_if #(.ADDR_W(ADDR_W)) bus ();

  prog_frame_loader #(
    .ADDR_W      (ADDR_W),
    .MAX_WORDS   (4),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CYC (24'd40)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every ICCM write strobe
  always @(negedge clk) begin
    if (bus.we_o) begin
      wr_addr.push_back(bus.addr_o);
      wr_data.push_back(bus.wdata_o);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_dv_i   = 1'b1;
    bus.rx_byte_i = b;
    @(negedge clk);
    bus.rx_dv_i   = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] s[]);
    foreach (s[i]) send_byte(s[i]);
  endtask

  task automatic restart();
    bus.prog_i = 1'b0;
    repeat (2) @(negedge clk);
    bus.prog_i = 1'b1;
    repeat (2) @(negedge clk);
    wr_addr.delete();
    wr_data.delete();
  endtask

  logic [7:0] s_good[];
  logic [7:0] s_bad[];
  logic [7:0] s_max[];
  int         wait_cyc;

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.prog_i    = 1'b0;
    bus.rx_dv_i   = 1'b0;
    bus.rx_byte_i = 8'h00;
    s_good = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h67, 8'h45, 8'h23, 8'h01, 8'h1B};
    s_bad  = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h67, 8'h45, 8'h23, 8'h01, 8'h1C};
    s_max  = new[20];
    s_max[0] = 8'hA5; s_max[1] = 8'h04; s_max[2] = 8'h00;
    for (int i = 3; i < 19; i++) s_max[i] = 8'h10;
    s_max[19] = 8'hFC;

    repeat (3) @(negedge clk);
    chk("rst_we",    32'(bus.we_o), 32'd0);
    chk("rst_addr",  32'(bus.addr_o), 32'd0);
    chk("rst_wdata", bus.wdata_o, 32'd0);
    chk("rst_busy",  32'(bus.busy_o), 32'd0);
    chk("rst_done",  32'(bus.done_o), 32'd0);
    chk("rst_err",   32'(bus.err_o), 32'd0);
    chk("rst_prst",  32'(bus.prog_rst_no), 32'd1);
    rst_n = 1'b1;

    // Good frame with junk before the sync byte
    bus.prog_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("sync_busy", 32'(bus.busy_o), 32'd1);
    chk("sync_prst", 32'(bus.prog_rst_no), 32'd0);
    send_byte(8'h00);
    send_byte(8'hFF);
    send_seq(s_good);
    @(negedge clk);
    chk("good_nwr",   32'(wr_addr.size()), 32'd2);
    chk("good_a0",    32'(wr_addr[0]), 32'd0);
    chk("good_d0",    wr_data[0], 32'h0000_0013);
    chk("good_a1",    32'(wr_addr[1]), 32'd1);
    chk("good_d1",    wr_data[1], 32'h0123_4567);
    chk("good_done",  32'(bus.done_o), 32'd1);
    chk("good_err",   32'(bus.err_o), 32'd0);
    chk("good_prst",  32'(bus.prog_rst_no), 32'd1);
    chk("good_busy",  32'(bus.busy_o), 32'd0);

    // Checksum mismatch: writes still land, core stays held
    restart();
    chk("bad_done_clr", 32'(bus.done_o), 32'd0);
    send_seq(s_bad);
    @(negedge clk);
    chk("bad_nwr",  32'(wr_addr.size()), 32'd2);
    chk("bad_d1",   wr_data[1], 32'h0123_4567);
    chk("bad_err",  32'(bus.err_o), 32'd2);
    chk("bad_done", 32'(bus.done_o), 32'd0);
    chk("bad_prst", 32'(bus.prog_rst_no), 32'd0);
    bus.prog_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("bad_idle_err",  32'(bus.err_o), 32'd2);
    chk("bad_idle_prst", 32'(bus.prog_rst_no), 32'd0);
    chk("bad_idle_busy", 32'(bus.busy_o), 32'd0);

    // Leaving SYNC after a failed load keeps the core held
    bus.prog_i = 1'b1;
    repeat (2) @(negedge clk);
    bus.prog_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("syncexit_err",  32'(bus.err_o), 32'd0);
    chk("syncexit_prst", 32'(bus.prog_rst_no), 32'd0);

    // Length errors: zero, MAX+1, 1025
    restart();
    send_seq('{8'hA5, 8'h00, 8'h00});
    @(negedge clk);
    chk("len0_err", 32'(bus.err_o), 32'd1);
    chk("len0_nwr", 32'(wr_addr.size()), 32'd0);
    restart();
    send_seq('{8'hA5, 8'h05, 8'h00});
    @(negedge clk);
    chk("len5_err", 32'(bus.err_o), 32'd1);
    restart();
    send_seq('{8'hA5, 8'h01, 8'h04});
    @(negedge clk);
    chk("len1025_err", 32'(bus.err_o), 32'd1);

    // Inter-byte timeout
    restart();
    send_seq('{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33});
    repeat (30) @(negedge clk);
    chk("tmo_early_err",  32'(bus.err_o), 32'd0);
    chk("tmo_early_busy", 32'(bus.busy_o), 32'd1);
    wait_cyc = 0;
    while (bus.err_o == 2'd0 && wait_cyc < 100) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("tmo_err",  32'(bus.err_o), 32'd3);
    chk("tmo_nwr",  32'(wr_addr.size()), 32'd0);
    chk("tmo_prst", 32'(bus.prog_rst_no), 32'd0);

    // Abort with a coincident byte
    restart();
    send_seq('{8'hA5, 8'h01, 8'h00, 8'h11});
    @(negedge clk);
    bus.prog_i    = 1'b0;
    bus.rx_dv_i   = 1'b1;
    bus.rx_byte_i = 8'h22;
    @(negedge clk);
    bus.rx_dv_i   = 1'b0;
    chk("abort_err", 32'(bus.err_o), 32'd3);
    @(negedge clk);
    chk("abort_nwr", 32'(wr_addr.size()), 32'd0);
    bus.prog_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_err_clr", 32'(bus.err_o), 32'd0);
    chk("abort_busy",    32'(bus.busy_o), 32'd1);

    // Reset mid-frame after 3 payload bytes, then a clean reload
    wr_addr.delete();
    wr_data.delete();
    send_seq('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00});
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_we",    32'(bus.we_o), 32'd0);
    chk("mid_rst_addr",  32'(bus.addr_o), 32'd0);
    chk("mid_rst_wdata", bus.wdata_o, 32'd0);
    chk("mid_rst_busy",  32'(bus.busy_o), 32'd0);
    chk("mid_rst_prst",  32'(bus.prog_rst_no), 32'd1);
    chk("mid_rst_nwr",   32'(wr_addr.size()), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_seq(s_good);
    @(negedge clk);
    chk("reload_nwr",  32'(wr_addr.size()), 32'd2);
    chk("reload_a0",   32'(wr_addr[0]), 32'd0);
    chk("reload_d0",   wr_data[0], 32'h0000_0013);
    chk("reload_d1",   wr_data[1], 32'h0123_4567);
    chk("reload_done", 32'(bus.done_o), 32'd1);

    // Word count exactly MAX_WORDS
    restart();
    send_seq(s_max);
    @(negedge clk);
    chk("max_nwr",  32'(wr_addr.size()), 32'd4);
    chk("max_alast", 32'(wr_addr[3]), 32'd3);
    chk("max_dlast", wr_data[3], 32'h1010_1010);
    chk("max_done", 32'(bus.done_o), 32'd1);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
